// File: rtl/axi_master_rd.sv
// axi_master_rd: single-burst AXI4 read master feeding a show-ahead local read buffer
module axi_master_rd #(
    parameter int ID_WIDTH     = 2,
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 512,
    parameter int ARUSER_WIDTH = 8,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [31:0]             i_snap_context,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arqos,
    output logic [3:0]              m_axi_arregion,
    output logic [1:0]              m_axi_arlock,
    output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic                    lcl_ibusy,
    input  logic                    lcl_istart,
    input  logic [ADDR_WIDTH-1:0]   lcl_iaddr,
    input  logic [7:0]              lcl_inum,
    input  logic                    lcl_ordy,
    output logic                    lcl_dv,
    output logic [DATA_WIDTH-1:0]   lcl_dout,
    output logic                    lcl_olast,
    output logic [5:0]              status
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH:0] head;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic [8:0]          beats, beats_nxt;
    logic                start, push, pop, at_len, done, len_err, unused_ctx;
    logic [1:0]          rd_error;

    assign m_axi_arid     = '0;
    assign m_axi_arsize   = 3'd6;
    assign m_axi_arburst  = 2'd1;
    assign m_axi_arcache  = 4'd3;
    assign m_axi_arprot   = 3'd0;
    assign m_axi_arqos    = 4'd0;
    assign m_axi_arregion = 4'd0;
    assign m_axi_arlock   = 2'd0;
    assign m_axi_aruser   = i_snap_context[ARUSER_WIDTH-1:0];
    assign unused_ctx     = ^i_snap_context[31:ARUSER_WIDTH];

    assign m_axi_arvalid = state == ADDR;
    assign m_axi_rready  = (state == DATA) & ~count[AW];
    assign lcl_ibusy     = state != IDLE;
    assign head          = mem[rd_ptr];
    assign lcl_dv        = count != '0;
    assign lcl_dout      = head[DATA_WIDTH-1:0];
    assign lcl_olast     = lcl_dv & head[DATA_WIDTH];
    assign status        = {~lcl_dv, count[AW], len_err, lcl_ibusy, rd_error};

    assign start     = lcl_istart & ~clear & (state == IDLE) & (lcl_inum != 8'd0);
    assign push      = m_axi_rvalid & m_axi_rready;
    assign pop       = lcl_dv & lcl_ordy;
    assign beats_nxt = beats + 9'd1;
    assign at_len    = beats_nxt == {1'b0, m_axi_arlen} + 9'd1;
    // The terminating beat is always marked last so DRAIN can exit even without rlast
    assign done      = push & (m_axi_rlast | at_len);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = start ? ADDR : IDLE;
            ADDR:  state_nxt = m_axi_arready ? DATA : ADDR;
            DATA:  state_nxt = done ? DRAIN : DATA;
            DRAIN: state_nxt = (pop & head[DATA_WIDTH]) ? IDLE : DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beats    <= '0;
            len_err  <= 1'b0;
            rd_error <= 2'b00;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_ptr + AW'(pop);
            count    <= count + CW'(push) - CW'(pop);
            beats    <= start ? 9'd0 : push ? beats_nxt : beats;
            len_err  <= len_err | (done & (m_axi_rlast ^ at_len));
            rd_error <= (push && m_axi_rresp != 2'b00) ? m_axi_rresp : rd_error;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_axi_araddr <= '0;
            m_axi_arlen  <= 8'd0;
        end else if (start) begin
            m_axi_araddr <= lcl_iaddr;
            m_axi_arlen  <= lcl_inum - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {done, m_axi_rdata};
    end
endmodule

// File: tb/tb_axi_master_rd.sv
// tb_axi_master_rd: random AXI slave and consumer around axi_master_rd, checked against a beat-queue model
module tb_axi_master_rd;
    localparam int DW = 512;
    localparam int AW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic [31:0]   ctx = 32'h1234_56a5;
    logic [1:0]    arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [3:0]    arcache;
    logic [2:0]    arprot;
    logic [3:0]    arqos;
    logic [3:0]    arregion;
    logic [1:0]    arlock;
    logic [7:0]    aruser;
    logic          arvalid, arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready;
    logic          lcl_ibusy, lcl_istart, lcl_ordy, lcl_dv, lcl_olast;
    logic [AW-1:0] lcl_iaddr;
    logic [7:0]    lcl_inum;
    logic [DW-1:0] lcl_dout;
    logic [5:0]    status;

    int            vectors = 0, miscompares = 0;
    int            plan_n = 0, plan_errb = 0, ar_wait = 0, ar_wcnt = 0;
    int            sent = 0, ar_cnt = 0, pops = 0, ordy_mode = 1;
    logic [1:0]    plan_resp = 2'b00;
    logic          sending = 1'b0, abort = 1'b0, ar_hs, r_hs, chk_dv = 1'b0;
    logic [DW-1:0] beat_data [256];
    logic [DW:0]   exp_q [$];
    logic [DW:0]   e;

    always #5 clk = ~clk;

    axi_master_rd dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .i_snap_context(ctx),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arqos(arqos),
        .m_axi_arregion(arregion), .m_axi_arlock(arlock), .m_axi_aruser(aruser),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .lcl_ibusy(lcl_ibusy), .lcl_istart(lcl_istart), .lcl_iaddr(lcl_iaddr), .lcl_inum(lcl_inum),
        .lcl_ordy(lcl_ordy), .lcl_dv(lcl_dv), .lcl_dout(lcl_dout), .lcl_olast(lcl_olast), .status(status)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // AXI read slave: delayed arready, beats with random gaps, rlast on the final planned beat
    initial begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
        forever begin
            @(negedge clk);
            ar_hs = arvalid & arready;
            r_hs  = rvalid & rready;
            if (chk_dv) chk("first_beat_latency", DW'(lcl_dv), DW'(1));
            chk_dv = r_hs && sent == 0;
            @(posedge clk);
            #1;
            if (abort) begin
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
                sending = 1'b0; ar_wcnt = 0; abort = 1'b0;
            end else begin
                if (ar_hs) begin
                    arready = 1'b0; ar_cnt++; sent = 0; sending = 1'b1; ar_wcnt = 0;
                end else if (arvalid && !arready) begin
                    if (ar_wcnt >= ar_wait) arready = 1'b1;
                    else ar_wcnt++;
                end
                if (r_hs) begin
                    sent++;
                    rvalid = 1'b0; rlast = 1'b0;
                    if (sent == plan_n) sending = 1'b0;
                end
                if (sending && !rvalid && $urandom_range(3) != 0) begin
                    rdata  = beat_data[sent];
                    rlast  = sent + 1 == plan_n;
                    rresp  = (sent + 1 == plan_errb) ? plan_resp : 2'b00;
                    rvalid = 1'b1;
                end
            end
        end
    end

    // Consumer: every pop must match the head of the expected-beat queue
    initial begin
        lcl_ordy = 1'b0;
        forever begin
            @(negedge clk);
            if (lcl_dv && lcl_ordy) begin
                pops++;
                if (exp_q.size() == 0) chk("extra_beat", DW'(lcl_dv), DW'(0));
                else begin
                    e = exp_q.pop_front();
                    chk("dout", lcl_dout, e[DW-1:0]);
                    chk("olast", DW'(lcl_olast), DW'(e[DW]));
                end
            end
            @(posedge clk);
            #1;
            lcl_ordy = (ordy_mode == 2) ? 1'($urandom_range(1)) : (ordy_mode == 1);
        end
    end

    task automatic launch(input logic [AW-1:0] addr, input int num, input int n,
                          input int errb, input logic [1:0] resp, input int aw);
        plan_n = n; plan_errb = errb; plan_resp = resp; ar_wait = aw;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < DW / 32; k++) beat_data[i][k*32 +: 32] = $urandom;
            exp_q.push_back({i == n - 1, beat_data[i]});
        end
        lcl_iaddr = addr; lcl_inum = 8'(num); lcl_istart = 1'b1;
        tick(1);
        lcl_istart = 1'b0;
        @(negedge clk);
        chk("arvalid", DW'(arvalid), DW'(1));
        chk("araddr", DW'(araddr), DW'(addr));
        chk("arlen", DW'(arlen), DW'(num - 1));
        chk("ibusy_start", DW'(lcl_ibusy), DW'(1));
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && lcl_ibusy; i++) tick(1);
        @(negedge clk);
        chk(tag, DW'(lcl_ibusy), DW'(0));
        chk({tag, "_drained"}, DW'(exp_q.size()), DW'(0));
    endtask

    task automatic pulse_clear(input bit use_rst);
        if (use_rst) rst_n = 1'b0;
        else clear = 1'b1;
        tick(1);
        rst_n = 1'b1; clear = 1'b0; abort = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("abort_arvalid", DW'(arvalid), DW'(0));
        chk("abort_rready", DW'(rready), DW'(0));
        chk("abort_dv", DW'(lcl_dv), DW'(0));
        chk("abort_ibusy", DW'(lcl_ibusy), DW'(0));
        chk("abort_status", DW'(status), DW'(6'b100000));
        tick(3);
    endtask

    task automatic wait_sent(input int n);
        for (int i = 0; i < 100 && sent < n; i++) tick(1);
        tick(1);
    endtask

    initial begin
        int p0, c0, num, errb;
        logic [1:0] resp, exp_err;
        lcl_istart = 1'b0; lcl_iaddr = '0; lcl_inum = 8'd0;
        tick(3);
        @(negedge clk);
        chk("rst_arvalid", DW'(arvalid), DW'(0));
        chk("rst_rready", DW'(rready), DW'(0));
        chk("rst_dv", DW'(lcl_dv), DW'(0));
        chk("rst_olast", DW'(lcl_olast), DW'(0));
        chk("rst_ibusy", DW'(lcl_ibusy), DW'(0));
        chk("rst_araddr", DW'(araddr), DW'(0));
        chk("rst_arlen", DW'(arlen), DW'(0));
        chk("rst_status", DW'(status), DW'(6'b100000));
        tick(1);
        rst_n = 1'b1;
        tick(2);

        ordy_mode = 1;
        launch(64'h1000, 4, 4, 0, 2'b00, 2);
        chk("arid", DW'(arid), DW'(0));
        chk("arsize", DW'(arsize), DW'(6));
        chk("arburst", DW'(arburst), DW'(1));
        chk("arcache", DW'(arcache), DW'(3));
        chk("arprot_qos_region_lock", DW'({arprot, arqos, arregion, arlock}), DW'(0));
        chk("aruser", DW'(aruser), DW'(8'ha5));
        wait_idle("basic_idle");
        chk("basic_ar_count", DW'(ar_cnt), DW'(1));

        ordy_mode = 0;
        p0 = pops;
        launch(64'h2000, 16, 16, 0, 2'b00, 0);
        tick(40);
        @(negedge clk);
        chk("full_rready", DW'(rready), DW'(0));
        chk("full_beats", DW'(sent), DW'(8));
        chk("full_flag", DW'(status[4]), DW'(1));
        ordy_mode = 1;
        wait_idle("full_idle");
        chk("full_pops", DW'(pops - p0), DW'(16));

        ordy_mode = 0;
        c0 = ar_cnt;
        launch(64'h3000, 2, 2, 0, 2'b00, 1);
        tick(6);
        lcl_iaddr = 64'h9999; lcl_inum = 8'd5; lcl_istart = 1'b1;
        tick(1);
        lcl_istart = 1'b0;
        tick(3);
        @(negedge clk);
        chk("busy_ar_count", DW'(ar_cnt - c0), DW'(1));
        chk("busy_arvalid", DW'(arvalid), DW'(0));
        chk("busy_araddr", DW'(araddr), DW'(64'h3000));
        chk("busy_ibusy", DW'(lcl_ibusy), DW'(1));
        ordy_mode = 1;
        wait_idle("busy_idle");
        tick(1);
        lcl_inum = 8'd0; lcl_istart = 1'b1;
        tick(1);
        lcl_istart = 1'b0;
        @(negedge clk);
        chk("zero_ibusy", DW'(lcl_ibusy), DW'(0));
        chk("zero_arvalid", DW'(arvalid), DW'(0));
        tick(3);
        chk("zero_ar_count", DW'(ar_cnt - c0), DW'(1));

        ordy_mode = 2;
        launch(64'h4000, 4, 4, 2, 2'b10, 1);
        wait_idle("err_idle");
        chk("rd_error", DW'(status[1:0]), DW'(2'b10));
        launch(64'h4100, 3, 3, 0, 2'b00, 0);
        wait_idle("err2_idle");
        chk("rd_error_sticky", DW'(status[1:0]), DW'(2'b10));
        pulse_clear(0);
        chk("rd_error_clear", DW'(status[1:0]), DW'(0));

        p0 = pops;
        launch(64'h5000, 5, 3, 0, 2'b00, 0);
        wait_idle("short_idle");
        chk("len_err", DW'(status[3]), DW'(1));
        chk("short_pops", DW'(pops - p0), DW'(3));
        pulse_clear(0);
        chk("len_err_clear", DW'(status[3]), DW'(0));

        ordy_mode = 0;
        launch(64'h6000, 8, 8, 0, 2'b00, 0);
        wait_sent(2);
        pulse_clear(0);
        launch(64'h7000, 8, 8, 0, 2'b00, 0);
        wait_sent(2);
        pulse_clear(1);
        launch(64'h8000, 4, 4, 0, 2'b00, 10);
        pulse_clear(0);

        ordy_mode = 2;
        exp_err = 2'b00;
        for (int t = 0; t < 25; t++) begin
            num  = int'($urandom_range(1, 20));
            resp = 2'($urandom_range(1, 3));
            errb = ($urandom_range(3) == 0) ? int'($urandom_range(1, num)) : 0;
            if (errb != 0) exp_err = resp;
            launch({$urandom, $urandom}, num, num, errb, resp, int'($urandom_range(3)));
            wait_idle("rand_idle");
            chk("rand_rd_error", DW'(status[1:0]), DW'(exp_err));
            chk("rand_len_err", DW'(status[3]), DW'(0));
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors applied", vectors);
        $fatal(1);
    end
endmodule

// File: doc/axi_master_rd.md
AXI_MASTER_RD -- requirements
Module: axi_master_rd

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 2, AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 512, data beat width.
REQ-004 SHALL have parameter ARUSER_WIDTH, default 8, aruser width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, read-buffer entries (power of 2, at least 2).
REQ-006 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-008 SHALL have port clear  in  1  synchronous soft clear.
REQ-009 SHALL have port i_snap_context  in  32  context; bits [ARUSER_WIDTH-1:0] drive m_axi_aruser.
REQ-010 SHALL have port m_axi_arid  out  ID_WIDTH  constant 0.
REQ-011 SHALL have port m_axi_araddr  out  ADDR_WIDTH  burst start address.
REQ-012 SHALL have port m_axi_arlen  out  8  beats minus 1.
REQ-013 SHALL have port m_axi_arsize  out  3  constant 3'd6.
REQ-014 SHALL have port m_axi_arburst  out  2  constant 2'd1 (INCR).
REQ-015 SHALL have ports m_axi_arcache/arprot/arqos/arregion/arlock  out  4/3/4/4/2  constants 3/0/0/0/0.
REQ-016 SHALL have port m_axi_aruser  out  ARUSER_WIDTH  from i_snap_context.
REQ-017 SHALL have port m_axi_arvalid  out  1  address valid.
REQ-018 SHALL have port m_axi_arready  in  1  address accepted.
REQ-019 SHALL have port m_axi_rdata  in  DATA_WIDTH  read beat.
REQ-020 SHALL have port m_axi_rresp  in  2  beat response.
REQ-021 SHALL have port m_axi_rlast  in  1  last beat.
REQ-022 SHALL have port m_axi_rvalid  in  1  beat valid.
REQ-023 SHALL have port m_axi_rready  out  1  beat accept.
REQ-024 SHALL have port lcl_ibusy  out  1  request in progress.
REQ-025 SHALL have port lcl_istart  in  1  one-cycle request pulse.
REQ-026 SHALL have port lcl_iaddr  in  ADDR_WIDTH  request address.
REQ-027 SHALL have port lcl_inum  in  8  beat count, 1..255.
REQ-028 SHALL have port lcl_ordy  in  1  consumer accepts lcl_dout this cycle.
REQ-029 SHALL have port lcl_dv  out  1  lcl_dout valid.
REQ-030 SHALL have port lcl_dout  out  DATA_WIDTH  head of buffer.
REQ-031 SHALL have port lcl_olast  out  1  lcl_dout is last beat of burst.
REQ-032 SHALL have port status  out  6  {fifo_empty, fifo_full, len_err, ibusy, rd_error[1:0]}.

Function
REQ-033 SHALL run FSM IDLE->ADDR on lcl_istart & ~ibusy & lcl_inum!=0, latching araddr=lcl_iaddr, arlen=lcl_inum-1 (8-bit), ibusy=1.
REQ-034 SHALL ignore lcl_istart when ibusy=1 or lcl_inum=0 (no AR, state unchanged).
REQ-035 SHALL assert arvalid exactly in ADDR, holding araddr/arlen stable; ADDR->DATA on arvalid&arready.
REQ-036 SHALL drive m_axi_rready = (state==DATA) & (fifo count < FIFO_DEPTH); beat pushed {rlast, rdata} on rvalid&rready.
REQ-037 SHALL count accepted beats; DATA->DRAIN on accepted beat with rlast or count reaching arlen+1, whichever first; mismatch between the two SHALL set len_err (sticky).
REQ-038 SHALL present buffer show-ahead: lcl_dv = ~fifo_empty, pop on lcl_dv & lcl_ordy; lcl_olast = lcl_dv & head marked last.
REQ-039 SHALL allow simultaneous push and pop, count unchanged; push never occurs when full, pop never when empty.
REQ-040 SHALL go DRAIN->IDLE and clear ibusy in the cycle the last-marked beat is popped; first accepted beat visible on lcl_dv one cycle after acceptance.
REQ-041 SHALL capture rd_error = rresp on any accepted beat with rresp!=0 (sticky, latest nonzero wins).
REQ-042 SHALL on clear: FSM to IDLE, arvalid=0, rready=0, buffer emptied, counters, len_err, rd_error zeroed; clear overrides simultaneous lcl_istart.

Reset
REQ-043 SHALL on rst_n=0 at clk edge set arvalid, rready, lcl_dv, lcl_olast, ibusy, araddr, arlen, status error bits to 0, fifo_empty=1, FSM=IDLE; reset mid-burst abandons burst identically.

Verification
REQ-044 SHALL test istart addr=0x1000 inum=4, arready after 2 cycles, 4 beats, ordy=1 -> arlen=3, 4 lcl_dv beats in order, olast on 4th, ibusy low after pop.
REQ-045 SHALL test inum=16 with ordy=0 -> rready drops after 8 beats, resumes as ordy=1 pops, no beat lost.
REQ-046 SHALL test istart during busy and inum=0 -> no second arvalid, ibusy unchanged.
REQ-047 SHALL test rresp=2'b10 on beat 2 -> status[1:0]=2'b10 until clear.
REQ-048 SHALL test rlast on beat 3 of arlen=4 -> len_err=1, DRAIN, olast on 3rd beat.
REQ-049 SHALL test clear and rst_n=0 mid-burst -> arvalid=0, lcl_dv=0, ibusy=0 next cycle.
